// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_ctrl
// Purpose  : Data-memory bus controller for the execute/writeback stage.
//            Converts a held load/store request into one AHB-lite-style
//            transfer (address phase, then data phase), stalls the pipeline
//            until the transfer ends, returns raw read data, and flags
//            misaligned requests, ERROR responses and hready timeouts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in, rst_n_in        clock (rising edge) / async active-low reset
//   mem_rd_req_in           load request, held until done or exception
//   mem_wr_req_in           store request, held until done or exception
//   addr_in[31:0]           byte address
//   wr_data_in[31:0]        store data (low byte/half significant)
//   size_in[1:0]            00 byte, 01 half, 10/11 word
//   ahb_hready_in           slave ready
//   ahb_resp_in             slave response, 1 = ERROR
//   ahb_hrdata_in[31:0]     slave read data
//   ahb_haddr_out[31:0]     bus address
//   ahb_htrans_out[1:0]     00 IDLE, 10 NONSEQ
//   ahb_hwrite_out          1 = write
//   ahb_hsize_out[2:0]      {0, size}
//   ahb_hwdata_out[31:0]    replicated write data for the data phase
//   stall_out               freeze upstream pipeline
//   done_out                one-cycle completion pulse
//   rd_data_out[31:0]       last successfully read word
//   misaligned_exc_out      misaligned request (combinational)
//   bus_err_exc_out         one-cycle error/timeout pulse
// ============================================================================
module dmem_bus_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        mem_rd_req_in,
   input  logic        mem_wr_req_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wr_data_in,
   input  logic [1:0]  size_in,
   input  logic        ahb_hready_in,
   input  logic        ahb_resp_in,
   input  logic [31:0] ahb_hrdata_in,
   output logic [31:0] ahb_haddr_out,
   output logic [1:0]  ahb_htrans_out,
   output logic        ahb_hwrite_out,
   output logic [2:0]  ahb_hsize_out,
   output logic [31:0] ahb_hwdata_out,
   output logic        stall_out,
   output logic        done_out,
   output logic [31:0] rd_data_out,
   output logic        misaligned_exc_out,
   output logic        bus_err_exc_out
);

   localparam int               C_CNT_W         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [C_CNT_W-1:0] C_WAIT_MAX    = C_CNT_W'(TIMEOUT_CYCLES);
   localparam logic [1:0]       C_HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]       C_HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [C_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [31:0]          haddr_q, haddr_d;
   logic [1:0]           htrans_q, htrans_d;
   logic                 hwrite_q, hwrite_d;
   logic [1:0]           hsize_q, hsize_d;
   logic [31:0]          hwdata_q, hwdata_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rd_data_q, rd_data_d;

   logic [1:0]           w_size_norm;
   logic                 w_misaligned;
   logic                 w_req;
   logic                 w_req_ok;
   logic                 w_timeout;
   logic                 w_done;
   logic                 w_bus_err;
   logic [31:0]          w_hwdata_rep;

   // Request decode: size 11 behaves exactly like a word access.
   always_comb begin
      w_size_norm = (size_in == 2'b11) ? 2'b10 : size_in;
      case (w_size_norm)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = addr_in[0];
         default: w_misaligned = |addr_in[1:0];
      endcase
      w_req    = mem_rd_req_in | mem_wr_req_in;
      w_req_ok = w_req & ~w_misaligned;
   end

   // Byte lanes are replicated so the slave can pick any lane for the
   // address it sees, without a lane-steering mux on our side.
   always_comb begin
      case (hsize_q)
         2'b00:   w_hwdata_rep = {4{wdata_q[7:0]}};
         2'b01:   w_hwdata_rep = {2{wdata_q[15:0]}};
         default: w_hwdata_rep = wdata_q;
      endcase
   end

   // Wait budget is exhausted only if hready is still low once the counter
   // has already seen TIMEOUT_CYCLES low cycles in this phase.
   assign w_timeout = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                      !ahb_hready_in && (wait_cnt_q == C_WAIT_MAX);

   // Next-state and pulse decode.  done/bus_err are decoded from the
   // registered state and the current response so the pipeline can be
   // released in the same cycle the slave completes.
   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      htrans_d   = htrans_q;
      hwrite_d   = hwrite_q;
      hsize_d    = hsize_q;
      hwdata_d   = hwdata_q;
      wdata_d    = wdata_q;
      rd_data_d  = rd_data_q;
      w_done     = 1'b0;
      w_bus_err  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_req_ok) begin
               haddr_d  = addr_in;
               hwrite_d = ~mem_rd_req_in;   // simultaneous rd+wr is a read
               hsize_d  = w_size_norm;
               wdata_d  = wr_data_in;
               htrans_d = C_HTRANS_NONSEQ;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (w_timeout) begin
               w_bus_err = 1'b1;
               htrans_d  = C_HTRANS_IDLE;
               state_d   = ST_IDLE;
            end else if (ahb_hready_in) begin
               htrans_d  = C_HTRANS_IDLE;
               hwdata_d  = w_hwdata_rep;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_timeout) begin
               w_bus_err = 1'b1;
               state_d   = ST_IDLE;
            end else if (ahb_hready_in) begin
               if (ahb_resp_in) begin
                  w_bus_err = 1'b1;
               end else begin
                  w_done = 1'b1;
                  if (!hwrite_q) begin
                     rd_data_d = ahb_hrdata_in;
                  end
               end
               state_d = ST_IDLE;
            end else if (ahb_resp_in) begin
               // First cycle of the two-cycle ERROR response.
               state_d = ST_ERR;
            end
         end
         default: begin
            w_bus_err = 1'b1;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Wait counter restarts on every state change so each phase gets its
   // own full budget.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !ahb_hready_in) begin
         wait_cnt_d = wait_cnt_q + C_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         haddr_q    <= '0;
         htrans_q   <= C_HTRANS_IDLE;
         hwrite_q   <= 1'b0;
         hsize_q    <= 2'b00;
         hwdata_q   <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         haddr_q    <= haddr_d;
         htrans_q   <= htrans_d;
         hwrite_q   <= hwrite_d;
         hsize_q    <= hsize_d;
         hwdata_q   <= hwdata_d;
         wdata_q    <= wdata_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign ahb_haddr_out      = haddr_q;
   assign ahb_htrans_out     = htrans_q;
   assign ahb_hwrite_out     = hwrite_q;
   assign ahb_hsize_out      = {1'b0, hsize_q};
   assign ahb_hwdata_out     = hwdata_q;
   assign rd_data_out        = rd_data_q;
   assign done_out           = w_done;
   assign bus_err_exc_out    = w_bus_err;
   assign misaligned_exc_out = (state_q == ST_IDLE) & w_req & w_misaligned;
   assign stall_out          = ((state_q != ST_IDLE) | w_req_ok) & ~w_done & ~w_bus_err;

endmodule
`default_nettype wire
